// File: rtl/cadence_meas.sv
// Crank cadence period measurement: times the interval between filtered rising
// edges, reports a scaled period, and flags loss of pedaling on timeout.
module cadence_meas #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cadence_rise,
    input  logic       cadence_filt,
    output logic [7:0] cadence_per,
    output logic       per_vld,
    output logic       not_pedaling
);

    localparam logic [23:0] LIMIT   = FAST_SIM ? 24'h007F80 : 24'hE4E1C0;
    localparam logic [7:0]  NO_PER  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      r_state;
    logic [23:0] r_cnt;
    logic [23:0] r_hi_cnt;
    logic [7:0]  r_per;
    logic        r_vld;
    logic        r_not_ped;

    logic        w_cnt_full;
    logic        w_stuck;
    logic        w_timeout;
    logic [7:0]  w_scaled;

    assign w_cnt_full = (r_cnt == LIMIT);
    assign w_stuck    = (r_hi_cnt == LIMIT);
    assign w_timeout  = w_cnt_full || w_stuck;
    assign w_scaled   = FAST_SIM ? r_cnt[14:7] : r_cnt[23:16];

    // Clocks since the last rise; saturates so a long gap can never alias.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 24'd0;
        end else if (cadence_rise) begin
            r_cnt <= 24'd1;
        end else if (!w_cnt_full) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    // Consecutive clocks with the filtered level high, for the stuck-high guard.
    always_ff @(posedge clk) begin
        if (rst || !cadence_filt) begin
            r_hi_cnt <= 24'd0;
        end else if (!w_stuck) begin
            r_hi_cnt <= r_hi_cnt + 24'd1;
        end
    end

    // NOTE: all state, outputs included, is assigned with <= in one clocked block so
    // every output is registered and the reset branch overrides any coincident event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_per     <= NO_PER;
            r_vld     <= 1'b0;
            r_not_ped <= 1'b1;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_per     <= NO_PER;
                    r_not_ped <= 1'b1;
                    if (cadence_rise) begin
                        r_state <= ARMED;
                    end
                end
                ARMED, RUN: begin
                    if (w_timeout) begin
                        // A rise on the timeout cycle restarts measurement as an idle rise.
                        r_per     <= NO_PER;
                        r_not_ped <= 1'b1;
                        r_state   <= cadence_rise ? ARMED : IDLE;
                    end else if (cadence_rise && !r_vld) begin
                        r_per     <= w_scaled;
                        r_vld     <= 1'b1;
                        r_not_ped <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_per     <= NO_PER;
                    r_not_ped <= 1'b1;
                end
            endcase
        end
    end

    assign cadence_per  = r_per;
    assign per_vld      = r_vld;
    assign not_pedaling = r_not_ped;

    a_vld_single: assert property (@(posedge clk) disable iff (rst) r_vld |=> !r_vld);
    a_cnt_bound:  assert property (@(posedge clk) r_cnt <= LIMIT);
    a_ped_state:  assert property (@(posedge clk) disable iff (rst)
                                   (r_state != RUN) |-> r_not_ped);

endmodule
